// File: rtl/cond_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : cond_pkg                                                |
// | Brief  : condition codes, flag bit indices and controller states |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : cond_check                                              |
// | Brief  : combinational condition-code evaluation against flags   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[N_BIT];
    assign w_z = i_flags[Z_BIT];
    assign w_c = i_flags[C_BIT];
    assign w_v = i_flags[V_BIT];

    always_comb begin
        o_pass = 1'b0;
        case (cond_e'(i_cond))
            EQ:      o_pass = w_z;
            NE:      o_pass = ~w_z;
            CS:      o_pass = w_c;
            CC:      o_pass = ~w_c;
            MI:      o_pass = w_n;
            PL:      o_pass = ~w_n;
            VS:      o_pass = w_v;
            VC:      o_pass = ~w_v;
            HI:      o_pass = w_c & ~w_z;
            LS:      o_pass = ~w_c | w_z;
            GE:      o_pass = (w_n == w_v);
            LT:      o_pass = (w_n != w_v);
            GT:      o_pass = ~w_z & (w_n == w_v);
            LE:      o_pass = w_z | (w_n != w_v);
            AL:      o_pass = 1'b1;
            NV:      o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cond_exec_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : cond_exec_ctrl                                          |
// | Brief  : conditional-execution sequencer with flag update        |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module cond_exec_ctrl
    import cond_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  COND,
    input  logic        s_bit,
    input  logic        wr_reg,
    input  logic        is_mem,
    input  logic        is_branch,
    input  logic [3:0]  ALUF,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        reg_we,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        done,
    output logic [3:0]  FLAGS,
    output logic [15:0] skip_cnt
);

    state_e      r_state;
    state_e      w_next;
    logic [3:0]  r_cond;
    logic        r_s_bit;
    logic        r_wr_reg;
    logic        r_is_mem;
    logic        r_is_branch;
    logic        r_pass;
    logic [3:0]  r_flags;
    logic [15:0] r_skip_cnt;
    logic        w_pass;
    logic        w_xfer;

    // Evaluated against the flags held before this instruction executes
    cond_check u_cond_check (
        .i_cond  (r_cond),
        .i_flags (r_flags),
        .o_pass  (w_pass)
    );

    assign w_xfer = instr_valid & instr_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_next = DECODE;
            DECODE:  w_next = w_pass ? EXEC : WB;
            EXEC:    w_next = r_is_mem ? MEM : WB;
            MEM:     if (mem_ready) w_next = WB;
            WB:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cond      <= 4'd0;
            r_s_bit     <= 1'b0;
            r_wr_reg    <= 1'b0;
            r_is_mem    <= 1'b0;
            r_is_branch <= 1'b0;
            r_pass      <= 1'b0;
            r_flags     <= 4'd0;
            r_skip_cnt  <= 16'd0;
        end else begin
            if (w_xfer) begin
                r_cond      <= COND;
                r_s_bit     <= s_bit;
                r_wr_reg    <= wr_reg;
                r_is_mem    <= is_mem;
                r_is_branch <= is_branch;
            end
            if (r_state == DECODE) begin
                r_pass <= w_pass;
                if (!w_pass) r_skip_cnt <= r_skip_cnt + 16'd1;
            end
            if ((r_state == EXEC) && r_s_bit) r_flags <= ALUF;
        end
    end

    always_comb begin
        instr_ready = (r_state == IDLE) & ~rst;
        mem_req     = (r_state == MEM);
        done        = 1'b0;
        reg_we      = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        if (r_state == WB) begin
            done    = 1'b1;
            reg_we  = r_pass & r_wr_reg;
            pc_load = r_pass & r_is_branch;
            pc_inc  = ~(r_pass & r_is_branch);
        end
    end

    assign FLAGS    = r_flags;
    assign skip_cnt = r_skip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_exec_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_cond_exec_ctrl                                       |
// | Brief  : directed self-checking bench for cond_exec_ctrl         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_cond_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  COND;
    logic        s_bit;
    logic        wr_reg;
    logic        is_mem;
    logic        is_branch;
    logic [3:0]  ALUF;
    logic        mem_ready;
    logic        mem_req;
    logic        reg_we;
    logic        pc_load;
    logic        pc_inc;
    logic        done;
    logic [3:0]  FLAGS;
    logic [15:0] skip_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .COND        (COND),
        .s_bit       (s_bit),
        .wr_reg      (wr_reg),
        .is_mem      (is_mem),
        .is_branch   (is_branch),
        .ALUF        (ALUF),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .reg_we      (reg_we),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .done        (done),
        .FLAGS       (FLAGS),
        .skip_cnt    (skip_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction from IDLE and follows it to retirement
    task automatic run_instr(input logic [3:0] c, input logic s, input logic wr,
                             input logic m, input logic br, input int mem_delay,
                             output int lat, output int mreq,
                             output logic we, output logic pl, output logic pi,
                             output logic stray);
        COND = c; s_bit = s; wr_reg = wr; is_mem = m; is_branch = br;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        COND = ~c; s_bit = ~s; wr_reg = ~wr; is_mem = ~m; is_branch = ~br;
        lat = 1; mreq = 0; stray = 1'b0;
        while (!done && lat < 40) begin
            stray = stray | reg_we | pc_load | pc_inc;
            if (mem_req) begin
                mreq++;
                mem_ready = (mreq == mem_delay);
            end else begin
                mem_ready = 1'b0;
            end
            step();
            lat++;
        end
        we = reg_we; pl = pc_load; pi = pc_inc;
        mem_ready = 1'b0;
        chk("retire_seen", {31'd0, done}, 32'd1);
        step();
    endtask

    int   lat, mreq;
    logic we, pl, pi, stray;
    logic seen_done;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; COND = 4'd0; s_bit = 1'b0; wr_reg = 1'b0;
        is_mem = 1'b0; is_branch = 1'b0; ALUF = 4'd0; mem_ready = 1'b0;
        step();
        step();
        chk("rst_ready",    {31'd0, instr_ready}, 32'd0);
        chk("rst_flags",    {28'd0, FLAGS}, 32'd0);
        chk("rst_skip",     {16'd0, skip_cnt}, 32'd0);
        chk("rst_outs",     {27'd0, mem_req, reg_we, pc_load, pc_inc, done}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        // AL with flag update: Z result
        ALUF = 4'b0100;
        run_instr(4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 0, lat, mreq, we, pl, pi, stray);
        chk("al_lat",   lat, 32'd3);
        chk("al_we",    {31'd0, we}, 32'd1);
        chk("al_pc",    {30'd0, pl, pi}, 32'b01);
        chk("al_stray", {31'd0, stray}, 32'd0);
        chk("al_flags", {28'd0, FLAGS}, 32'h4);

        // NE with Z=1 is skipped; s_bit must not touch flags
        ALUF = 4'b1111;
        run_instr(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 0, lat, mreq, we, pl, pi, stray);
        chk("ne_lat",   lat, 32'd2);
        chk("ne_we",    {31'd0, we}, 32'd0);
        chk("ne_pc",    {30'd0, pl, pi}, 32'b01);
        chk("ne_skip",  {16'd0, skip_cnt}, 32'd1);
        chk("ne_flags", {28'd0, FLAGS}, 32'h4);

        // HI with Z=1, C=0 is skipped
        run_instr(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, mreq, we, pl, pi, stray);
        chk("hi_lat",  lat, 32'd2);
        chk("hi_skip", {16'd0, skip_cnt}, 32'd2);

        // Set N=1, V=0
        ALUF = 4'b1000;
        run_instr(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 0, lat, mreq, we, pl, pi, stray);
        chk("setn_flags", {28'd0, FLAGS}, 32'h8);
        chk("setn_we",    {31'd0, we}, 32'd0);

        run_instr(4'b1010, 1'b0, 1'b1, 1'b0, 1'b1, 0, lat, mreq, we, pl, pi, stray);
        chk("ge_lat",  lat, 32'd2);
        chk("ge_pc",   {30'd0, pl, pi}, 32'b01);
        chk("ge_skip", {16'd0, skip_cnt}, 32'd3);

        run_instr(4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 0, lat, mreq, we, pl, pi, stray);
        chk("lt_lat",  lat, 32'd3);
        chk("lt_pc",   {30'd0, pl, pi}, 32'b10);
        chk("lt_we",   {31'd0, we}, 32'd0);
        chk("lt_skip", {16'd0, skip_cnt}, 32'd3);

        // Memory access with mem_ready on the 4th MEM cycle
        run_instr(4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 4, lat, mreq, we, pl, pi, stray);
        chk("mem_lat",   lat, 32'd7);
        chk("mem_req_n", mreq, 32'd4);
        chk("mem_we",    {31'd0, we}, 32'd1);
        chk("mem_stray", {31'd0, stray}, 32'd0);
        chk("mem_flags", {28'd0, FLAGS}, 32'h8);

        // Reset while waiting in MEM; flags were updated in EXEC first
        ALUF = 4'b1111;
        COND = 4'b1110; s_bit = 1'b1; wr_reg = 1'b1; is_mem = 1'b1; is_branch = 1'b0;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        chk("abort_in_mem", {31'd0, mem_req}, 32'd1);
        chk("abort_flags_pre", {28'd0, FLAGS}, 32'hF);
        rst = 1'b1;
        step();
        chk("abort_rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("abort_rst_outs",  {27'd0, mem_req, reg_we, pc_load, pc_inc, done}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_flags", {28'd0, FLAGS}, 32'd0);
        chk("abort_skip",  {16'd0, skip_cnt}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            seen_done = seen_done | done | reg_we;
            step();
        end
        mem_ready = 1'b0;
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        chk("abort_idle",    {31'd0, instr_ready}, 32'd1);

        // Counter wrap: start just below the top
        force dut.r_skip_cnt = 16'hFFFE;
        step();
        release dut.r_skip_cnt;
        run_instr(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, mreq, we, pl, pi, stray);
        chk("nv_lat",    lat, 32'd2);
        chk("wrap_top",  {16'd0, skip_cnt}, 32'hFFFF);
        run_instr(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, mreq, we, pl, pi, stray);
        chk("wrap_zero", {16'd0, skip_cnt}, 32'h0000);
        chk("wrap_we",   {31'd0, we}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
